// File: rtl/sale_controller.sv
// Ticket-sale sequencer: selection, coin payment, ticket handoff, change.
// Define SALE_TIMEOUT_EN to build the PAY inactivity refund timer.
module sale_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_valid,
  input  logic [3:0] sel_price,
  input  logic [1:0] sel_amount,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       cancel,
  output logic       tkt_valid,
  input  logic       tkt_ready,
  output logic       change_valid,
  input  logic       change_ack,
  output logic [4:0] change,
  output logic       refund,
  output logic       coin_reject,
  output logic [3:0] present_state,
  output logic [4:0] total_price,
  output logic [4:0] real_pay
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    PAY  = 4'b0010,
    DISP = 4'b0100,
    CHG  = 4'b1000
  } state_t;

  state_t     state;
  logic [1:0] tickets_left;
  logic [4:0] coin_amt;
  logic [5:0] product;
  logic [5:0] pay_sum;
  logic       sel_ok;
  logic       coin_ok;
  logic       fare_met;
  logic       expired;

  // Coin code to value; the invalid code maps to 0 and is never accepted.
  always_comb begin
    coin_amt = 5'd0;
    unique case (coin_value)
      2'b00: coin_amt = 5'd1;
      2'b01: coin_amt = 5'd5;
      2'b10: coin_amt = 5'd10;
      default: coin_amt = 5'd0;
    endcase
  end

  assign product  = {2'b00, sel_price} * {4'b0000, sel_amount};
  assign sel_ok   = sel_valid && (sel_price != 4'd0)
                 && (sel_amount != 2'd0) && (product <= 6'd31);
  assign pay_sum  = {1'b0, real_pay} + {1'b0, coin_amt};
  assign coin_ok  = coin_valid && (coin_value != 2'b11)
                 && (pay_sum <= 6'd31);
  assign fare_met = pay_sum[4:0] >= total_price;

`ifdef SALE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Reaching zero marks the last of TIMEOUT_CYCLES quiet PAY cycles.
  assign expired = (tmo_cnt == '0);

  // Inactivity counter: reload on PAY entry and accepted coins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= TLOAD;
    end else if (state == IDLE && sel_ok) begin
      tmo_cnt <= TLOAD;
    end else if (state == PAY && !cancel && coin_ok) begin
      tmo_cnt <= TLOAD;
    end else if (state == PAY && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end
`else
  logic unused_cfg;

  assign expired    = 1'b0;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  // Sale sequencer with its latched fare, payment and ticket count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tickets_left <= 2'd0;
      total_price  <= 5'd0;
      real_pay     <= 5'd0;
      refund       <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      unique case (1'b1)
        state[0]: begin
          coin_reject <= coin_valid;
          if (sel_ok) begin
            total_price  <= product[4:0];
            tickets_left <= sel_amount;
            real_pay     <= 5'd0;
            state        <= PAY;
          end
        end
        state[1]: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            refund      <= 1'b1;
            state       <= CHG;
          end else if (coin_ok) begin
            real_pay <= pay_sum[4:0];
            if (fare_met) state <= DISP;
          end else begin
            coin_reject <= coin_valid;
            if (expired) begin
              refund <= 1'b1;
              state  <= CHG;
            end
          end
        end
        state[2]: begin
          coin_reject <= coin_valid;
          if (tkt_ready) begin
            tickets_left <= tickets_left - 2'd1;
            if (tickets_left == 2'd1) begin
              refund <= 1'b0;
              state  <= CHG;
            end
          end
        end
        state[3]: begin
          coin_reject <= coin_valid;
          if (change_ack) begin
            real_pay    <= 5'd0;
            total_price <= 5'd0;
            refund      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign present_state = state;
  assign tkt_valid     = (state == DISP);
  assign change_valid  = (state == CHG);
  assign change        = (state != CHG) ? 5'd0
                       : refund ? real_pay
                       : real_pay - total_price;

endmodule

// File: tb/tb_sale_controller.sv
// Bench for sale_controller: vector table, hand sequences, random vs model.
// Timeout behaviour follows SALE_TIMEOUT_EN as the DUT is built.
module tb_sale_controller;

  localparam int T = 16;
`ifdef SALE_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam logic [3:0] S_I = 4'b0001;
  localparam logic [3:0] S_P = 4'b0010;
  localparam logic [3:0] S_D = 4'b0100;
  localparam logic [3:0] S_C = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_price = '0;
  logic [1:0] sel_amount = '0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = '0;
  logic       cancel = 1'b0;
  logic       tkt_valid;
  logic       tkt_ready = 1'b0;
  logic       change_valid;
  logic       change_ack = 1'b0;
  logic [4:0] change;
  logic       refund;
  logic       coin_reject;
  logic [3:0] present_state;
  logic [4:0] total_price;
  logic [4:0] real_pay;

  int checks = 0;
  int errors = 0;

  sale_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_valid(sel_valid), .sel_price(sel_price),
    .sel_amount(sel_amount),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .cancel(cancel),
    .tkt_valid(tkt_valid), .tkt_ready(tkt_ready),
    .change_valid(change_valid), .change_ack(change_ack),
    .change(change), .refund(refund),
    .coin_reject(coin_reject),
    .present_state(present_state),
    .total_price(total_price), .real_pay(real_pay)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       tv;
    logic       cv;
    logic [4:0] ch;
    logic       rf;
    logic       rj;
    logic [4:0] tp;
    logic [4:0] rp;
  } obs_t;

  typedef struct {
    logic       sv;
    logic [3:0] pr;
    logic [1:0] am;
    logic       cv;
    logic [1:0] co;
    logic       ca;
    logic       tr;
    logic       ak;
    obs_t       exp;
  } vec_t;

  vec_t vq[$];

  function automatic obs_t o(logic [3:0] st, logic tv, logic cv,
                             logic [4:0] ch, logic rf, logic rj,
                             logic [4:0] tp, logic [4:0] rp);
    obs_t r;
    r = '{st, tv, cv, ch, rf, rj, tp, rp};
    return r;
  endfunction

  function automatic vec_t v(logic sv, logic [3:0] pr, logic [1:0] am,
                             logic cv, logic [1:0] co, logic ca,
                             logic tr, logic ak, obs_t e);
    vec_t r;
    r = '{sv, pr, am, cv, co, ca, tr, ak, e};
    return r;
  endfunction

  function automatic obs_t sample();
    return '{present_state, tkt_valid, change_valid, change,
             refund, coin_reject, total_price, real_pay};
  endfunction

  task automatic check_obs(string name, obs_t e);
    obs_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got st=%b tv=%b cv=%b ch=%0d rf=%b rj=%b tp=%0d rp=%0d exp st=%b tv=%b cv=%b ch=%0d rf=%b rj=%b tp=%0d rp=%0d",
               name, a.st, a.tv, a.cv, a.ch, a.rf, a.rj, a.tp, a.rp,
               e.st, e.tv, e.cv, e.ch, e.rf, e.rj, e.tp, e.rp);
    end
  endtask

  task automatic drive(logic sv, logic [3:0] pr, logic [1:0] am,
                       logic cv, logic [1:0] co, logic ca,
                       logic tr, logic ak);
    sel_valid = sv; sel_price = pr; sel_amount = am;
    coin_valid = cv; coin_value = co; cancel = ca;
    tkt_ready = tr; change_ack = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase 0 idle, 1 paying, 2 dispensing, 3 change.
  int m_ph, m_total, m_pay, m_tk, m_quiet;
  bit m_ref, m_rej;

  task automatic model_reset();
    m_ph = 0; m_total = 0; m_pay = 0; m_tk = 0; m_quiet = 0;
    m_ref = 0; m_rej = 0;
  endtask

  function automatic int coin_val(logic [1:0] c);
    if (c == 2'd0) return 1;
    if (c == 2'd1) return 5;
    if (c == 2'd2) return 10;
    return -1;
  endfunction

  task automatic model_step();
    int cval;
    cval = coin_val(coin_value);
    m_rej = coin_valid;
    if (m_ph == 0) begin
      if (sel_valid && sel_price != 0 && sel_amount != 0
          && int'(sel_price) * int'(sel_amount) <= 31) begin
        m_total = int'(sel_price) * int'(sel_amount);
        m_tk = int'(sel_amount);
        m_pay = 0; m_quiet = 0; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (cancel) begin
        m_ref = 1; m_ph = 3;
      end else if (coin_valid && cval > 0 && m_pay + cval <= 31) begin
        m_rej = 0;
        m_pay += cval; m_quiet = 0;
        if (m_pay >= m_total) m_ph = 2;
      end else begin
        m_quiet++;
        if (TMO && m_quiet >= T) begin
          m_ref = 1; m_ph = 3;
        end
      end
    end else if (m_ph == 2) begin
      if (tkt_ready) begin
        m_tk--;
        if (m_tk == 0) begin
          m_ref = 0; m_ph = 3;
        end
      end
    end else begin
      if (change_ack) begin
        m_pay = 0; m_total = 0; m_ref = 0; m_ph = 0;
      end
    end
  endtask

  function automatic obs_t model_obs();
    int ch;
    ch = 0;
    if (m_ph == 3) ch = m_ref ? m_pay : m_pay - m_total;
    return o(4'(1 << m_ph), m_ph == 2, m_ph == 3, 5'(ch),
             m_ref, m_rej, 5'(m_total), 5'(m_pay));
  endfunction

  initial begin
    // Normal purchase: 4 x 2, coins 5 + 5, change 2.
    vq.push_back(v(1,4,2,0,0,0,0,0, o(S_P,0,0,0,0,0,8,0)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_P,0,0,0,0,0,8,5)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_D,1,0,0,0,0,8,10)));
    vq.push_back(v(0,0,0,0,0,0,1,0, o(S_D,1,0,0,0,0,8,10)));
    vq.push_back(v(0,0,0,0,0,0,1,0, o(S_C,0,1,2,0,0,8,10)));
    vq.push_back(v(0,0,0,0,0,0,0,1, o(S_I,0,0,0,0,0,0,0)));
    // Oversized selection, coin in IDLE.
    vq.push_back(v(1,12,3,0,0,0,0,0, o(S_I,0,0,0,0,0,0,0)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_I,0,0,0,0,1,0,0)));
    vq.push_back(v(0,0,0,0,0,0,0,0, o(S_I,0,0,0,0,0,0,0)));
    // Overflow coin at 25 of 30.
    vq.push_back(v(1,15,2,0,0,0,0,0, o(S_P,0,0,0,0,0,30,0)));
    vq.push_back(v(0,0,0,1,2,0,0,0, o(S_P,0,0,0,0,0,30,10)));
    vq.push_back(v(0,0,0,1,2,0,0,0, o(S_P,0,0,0,0,0,30,20)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_P,0,0,0,0,0,30,25)));
    vq.push_back(v(0,0,0,1,2,0,0,0, o(S_P,0,0,0,0,1,30,25)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_D,1,0,0,0,0,30,30)));
    vq.push_back(v(0,0,0,0,0,0,1,0, o(S_D,1,0,0,0,0,30,30)));
    vq.push_back(v(0,0,0,0,0,0,1,0, o(S_C,0,1,0,0,0,30,30)));
    vq.push_back(v(0,0,0,0,0,0,0,1, o(S_I,0,0,0,0,0,0,0)));
    // Cancel racing a coin.
    vq.push_back(v(1,6,1,0,0,0,0,0, o(S_P,0,0,0,0,0,6,0)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_P,0,0,0,0,0,6,5)));
    vq.push_back(v(0,0,0,1,0,1,0,0, o(S_C,0,1,5,1,1,6,5)));
    vq.push_back(v(0,0,0,0,0,0,0,1, o(S_I,0,0,0,0,0,0,0)));
    // Invalid coin code, then a refund of 1.
    vq.push_back(v(1,3,1,0,0,0,0,0, o(S_P,0,0,0,0,0,3,0)));
    vq.push_back(v(0,0,0,1,3,0,0,0, o(S_P,0,0,0,0,1,3,0)));
    vq.push_back(v(0,0,0,1,0,0,0,0, o(S_P,0,0,0,0,0,3,1)));
    vq.push_back(v(0,0,0,0,0,1,0,0, o(S_C,0,1,1,1,0,3,1)));
    vq.push_back(v(0,0,0,0,0,0,0,1, o(S_I,0,0,0,0,0,0,0)));
    // Zero price / zero amount ignored.
    vq.push_back(v(1,0,2,0,0,0,0,0, o(S_I,0,0,0,0,0,0,0)));
    vq.push_back(v(1,5,0,0,0,0,0,0, o(S_I,0,0,0,0,0,0,0)));
    // Coins and cancel during DISPENSE and CHANGE.
    vq.push_back(v(1,2,1,0,0,0,0,0, o(S_P,0,0,0,0,0,2,0)));
    vq.push_back(v(0,0,0,1,1,0,0,0, o(S_D,1,0,0,0,0,2,5)));
    vq.push_back(v(0,0,0,1,0,1,0,0, o(S_D,1,0,0,0,1,2,5)));
    vq.push_back(v(0,0,0,0,0,0,1,0, o(S_C,0,1,3,0,0,2,5)));
    vq.push_back(v(0,0,0,1,0,0,0,1, o(S_I,0,0,0,0,1,0,0)));
    vq.push_back(v(0,0,0,0,0,0,0,0, o(S_I,0,0,0,0,0,0,0)));

    drive(0,0,0,0,0,0,0,0);
    rst_n = 1'b0;
    tick(); tick();
    check_obs("reset", o(S_I,0,0,0,0,0,0,0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sv, vq[i].pr, vq[i].am, vq[i].cv,
            vq[i].co, vq[i].ca, vq[i].tr, vq[i].ak);
      tick();
      check_obs($sformatf("vec%0d", i), vq[i].exp);
    end

    // Backpressure: 3 tickets, ready low 5 cycles, then async reset.
    drive(1,1,3,0,0,0,0,0); tick();
    drive(0,0,0,1,1,0,0,0); tick();
    check_obs("bp_enter", o(S_D,1,0,0,0,0,3,5));
    drive(0,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_obs("bp_hold", o(S_D,1,0,0,0,0,3,5));
    end
    drive(0,0,0,0,0,0,1,0); tick(); tick();
    check_obs("bp_two_left", o(S_D,1,0,0,0,0,3,5));
    #2 rst_n = 1'b0;
    #1 check_obs("async_rst", o(S_I,0,0,0,0,0,0,0));
    drive(0,0,0,0,0,0,0,0);
    tick();
    rst_n = 1'b1;
    tick();

    // Inactivity in PAY after a single coin of 1.
    drive(1,5,1,0,0,0,0,0); tick();
    drive(0,0,0,1,0,0,0,0); tick();
    check_obs("tmo_coin", o(S_P,0,0,0,0,0,5,1));
    drive(0,0,0,0,0,0,0,0);
    for (int i = 0; i < T - 1; i++) begin
      tick();
      check_obs("tmo_wait", o(S_P,0,0,0,0,0,5,1));
    end
    tick();
    if (TMO) begin
      check_obs("tmo_fire", o(S_C,0,1,1,1,0,5,1));
    end else begin
      check_obs("no_tmo", o(S_P,0,0,0,0,0,5,1));
      for (int i = 0; i < 3 * T; i++) tick();
      check_obs("no_tmo_long", o(S_P,0,0,0,0,0,5,1));
      drive(0,0,0,0,0,1,0,0); tick();
      check_obs("no_tmo_cancel", o(S_C,0,1,1,1,0,5,1));
    end
    drive(0,0,0,0,0,0,0,1); tick();
    check_obs("tmo_ack", o(S_I,0,0,0,0,0,0,0));

    // Random traffic against the model.
    drive(0,0,0,0,0,0,0,0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      logic cvr, car;
      cvr = 1'($urandom_range(0, 1));
      car = ($urandom_range(0, 19) == 0);
      if ((i / 100) % 5 == 4) begin
        cvr = 1'b0;
        car = 1'b0;
      end
      drive($urandom_range(0, 3) == 0,
            4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)),
            cvr, 2'($urandom_range(0, 3)), car,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0);
      model_step();
      tick();
      check_obs("rand", model_obs());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
